// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM microphone front end.
// Generates the microphone clock, samples the 1-bit PDM stream and produces 8-bit amplitude
// samples from two ones-count windows staggered by half a window.
// Optional build macro PDM_TEST_PATTERN_EN adds an 8-bit ramp source selected by test_mode_i.
module pdm_decimator #(
    parameter int unsigned CLK_DIV = 20,
    parameter int unsigned WINDOW  = 200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       m_clk_o,
    output logic       m_clk_en_o,
    input  logic       m_data_i,
    input  logic       test_mode_i,
    output logic [7:0] amplitude_o,
    output logic       amplitude_valid_o
);

    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SampW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned AccW  = $clog2(WINDOW + 1);

    localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0]  DivHalf   = DivW'(CLK_DIV / 2);
    localparam logic [SampW-1:0] SampLastA = SampW'(WINDOW - 1);
    localparam logic [SampW-1:0] SampLastB = SampW'(WINDOW / 2 - 1);

    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             m_clk_q, m_clk_en_q;
    logic [1:0]       sync_q;
    logic             bit_s;
    logic [SampW-1:0] samp_cnt_q, samp_cnt_d;
    logic [AccW-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic             first_b_q, first_b_d;
    logic             close;
    logic [AccW-1:0]  close_val;
    logic [7:0]       sat_val, amp_d;
    logic [7:0]       amplitude_q;
    logic             amplitude_valid_q;

    // Divider next count.
    always_comb begin
        div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
    end

    // m_clk and its strobe are decoded from the next count so both rise in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            m_clk_q    <= 1'b0;
            m_clk_en_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            m_clk_q    <= (div_cnt_d >= DivHalf);
            m_clk_en_q <= (div_cnt_d == DivHalf);
        end
    end

    // Two-flop synchroniser for the asynchronous PDM input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], m_data_i};
        end
    end

    assign bit_s = sync_q[1];

    // Window accumulation and close detection; A and B close half a window apart.
    always_comb begin
        samp_cnt_d = samp_cnt_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        first_b_d  = first_b_q;
        close      = 1'b0;
        close_val  = '0;
        if (m_clk_en_q) begin
            samp_cnt_d = (samp_cnt_q == SampLastA) ? '0 : samp_cnt_q + SampW'(1);
            acc_a_d    = acc_a_q + AccW'(bit_s);
            acc_b_d    = acc_b_q + AccW'(bit_s);
            if (samp_cnt_q == SampLastA) begin
                close     = 1'b1;
                close_val = acc_a_d;
                acc_a_d   = '0;
            end
            if (samp_cnt_q == SampLastB) begin
                // The first B window after reset is partial, so it only restarts the count.
                close     = first_b_q;
                close_val = acc_b_d;
                acc_b_d   = '0;
                first_b_d = 1'b1;
            end
        end
    end

    // Window counters and accumulators.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_cnt_q <= '0;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            first_b_q  <= 1'b0;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            first_b_q  <= first_b_d;
        end
    end

    // Saturate the window count to 8 bits.
    always_comb begin
        sat_val = (32'(close_val) > 32'd255) ? 8'hFF : 8'(close_val);
    end

`ifdef PDM_TEST_PATTERN_EN
    logic [7:0] ramp_q;

    // Ramp replaces the count while test_mode_i is high and steps once per strobe.
    always_comb begin
        amp_d = test_mode_i ? ramp_q : sat_val;
    end

    // Ramp register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ramp_q <= '0;
        end else if (close && test_mode_i) begin
            ramp_q <= ramp_q + 8'd1;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Without the test pattern the window count is always the output.
    always_comb begin
        amp_d = sat_val;
    end
`endif

    // Output register: amplitude holds between strobes, valid is a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            amplitude_q       <= '0;
            amplitude_valid_q <= 1'b0;
        end else begin
            amplitude_valid_q <= close;
            if (close) begin
                amplitude_q <= amp_d;
            end
        end
    end

    assign m_clk_o           = m_clk_q;
    assign m_clk_en_o        = m_clk_en_q;
    assign amplitude_o       = amplitude_q;
    assign amplitude_valid_o = amplitude_valid_q;

endmodule
